adder_slice_sequencer: RTL

Multi-cycle controller that computes a WIDTH-bit add or subtract by time-sharing one narrow SLICE-bit carry-lookahead adder slice, built from PFA cells, across successive operand chunks, least significant chunk first. Operands arrive on a valid/ready request port. The slice is driven from registered outputs and held for a programmable settle window so NAND-level propagation completes before capture. The result, carry-out and signed overflow are returned on a valid/ready response port. The block sits between the ALU issue logic and the shared gate-level adder slice.

---
 rtl/adder_seq_pkg.sv | 24 ++
 rtl/adder_slice_sequencer_if.sv | 36 +++
 rtl/adder_slice_sequencer_settle_counter.sv | 35 +++
 rtl/adder_slice_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared definitions for the chunked adder sequencer.
//
// Contents:
//   seq_state_t   - sequencer state encoding (IDLE, EVAL, DONE)
//   calc_chunks() - number of slice-wide chunks that make up one operand
//   DEFAULT_*     - default operand, slice and settle-window sizes
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_SLICE  = 8;
    localparam int DEFAULT_SETTLE = 2;

    // Operand chunks processed per operation, least significant first.
    function automatic int calc_chunks(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/adder_slice_sequencer_if.sv
// Request/response bus of the adder sequencer.
//
// Signals:
//   req_valid/req_ready       - request handshake
//   req_a, req_b, req_sub     - operands and operation (1 = subtract)
//   rsp_valid/rsp_ready       - response handshake
//   rsp_sum, rsp_cout, rsp_ovf- result, carry out of the MSB, signed overflow
// Modports:
//   master - ALU issue logic (issues requests, consumes responses)
//   slave  - the sequencer
interface adder_slice_sequencer_if #(
    parameter int WIDTH = 32
);

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_sub;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf
    );

endinterface

// File: rtl/adder_slice_sequencer_settle_counter.sv
// settle_counter: loadable down-counter with a zero flag, used to hold
// inputs on a gate-level block for a fixed number of cycles.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset (count -> 0)
//   load        - load load_value (takes priority over dec)
//   dec         - decrement; saturates at zero
//   load_value  - value loaded on load
//   zero        - count is zero
module settle_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/adder_slice_sequencer.sv
// adder_slice_sequencer: computes a WIDTH-bit add/subtract by time-sharing
// an external SLICE-bit adder slice over WIDTH/SLICE chunks, LSB chunk first.
// Each chunk is held on the slice for SETTLE_CYCLES cycles before capture.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   bus (slave)       - request/response handshake bus
//   slice_a, slice_b  - registered chunk of A and of effective B (~B on sub)
//   slice_cin         - registered carry into the slice (also the carry register)
//   slice_sum         - slice sum, sampled only on capture edges
//   slice_cout        - slice carry-out, sampled only on capture edges
module adder_slice_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SLICE         = DEFAULT_SLICE,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE
) (
    input  logic                clk,
    input  logic                reset,
    adder_slice_sequencer_if.slave bus,
    output logic [SLICE-1:0]    slice_a,
    output logic [SLICE-1:0]    slice_b,
    output logic                slice_cin,
    input  logic [SLICE-1:0]    slice_sum,
    input  logic                slice_cout
);

    localparam int CHUNKS = calc_chunks(WIDTH, SLICE);
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_width
            $error("adder_slice_sequencer: WIDTH must be a multiple of SLICE");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("adder_slice_sequencer: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    seq_state_t       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic [WIDTH-1:0] b_eff_in;
    logic [WIDTH-1:0] sum_reg;
    logic             req_ready_reg;
    logic             rsp_valid_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             accept;
    logic             capture;
    logic             last_chunk;
    logic             settle_zero;

    // Subtraction is A + ~B + 1; the +1 enters as the first carry-in.
    always_comb begin
        b_eff_in   = bus.req_sub ? ~bus.req_b : bus.req_b;
        next_idx   = idx + IDX_W'(1);
        last_chunk = (idx == IDX_W'(CHUNKS - 1));
        accept     = (state == IDLE) && bus.req_valid;
        capture    = (state == EVAL) && settle_zero;
    end

    // The settle window restarts at acceptance and after every capture that
    // moves on to another chunk.
    settle_counter #(
        .W (CNT_W)
    ) u_settle (
        .clk        (clk),
        .reset      (reset),
        .load       (accept || (capture && !last_chunk)),
        .dec        (state == EVAL),
        .load_value (CNT_W'(SETTLE_CYCLES - 1)),
        .zero       (settle_zero)
    );

    // Sequencer FSM. All slice and response outputs are registers, so nothing
    // from slice_sum/slice_cout reaches an output without a clock edge.
    // The result register accumulates chunk by chunk; it is only meaningful
    // while rsp_valid is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            idx           <= '0;
            sum_reg       <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            slice_a       <= '0;
            slice_b       <= '0;
            slice_cin     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_reg         <= bus.req_a;
                        b_reg         <= b_eff_in;
                        idx           <= '0;
                        slice_a       <= bus.req_a[SLICE-1:0];
                        slice_b       <= b_eff_in[SLICE-1:0];
                        slice_cin     <= bus.req_sub;
                        req_ready_reg <= 1'b0;
                        state         <= EVAL;
                    end
                end
                EVAL: begin
                    if (settle_zero) begin
                        sum_reg[idx*SLICE +: SLICE] <= slice_sum;
                        slice_cin                   <= slice_cout;
                        if (!last_chunk) begin
                            idx     <= next_idx;
                            slice_a <= a_reg[next_idx*SLICE +: SLICE];
                            slice_b <= b_reg[next_idx*SLICE +: SLICE];
                        end else begin
                            // Overflow: operands agree in sign but the result does not.
                            cout_reg      <= slice_cout;
                            ovf_reg       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                             (slice_sum[SLICE-1] != a_reg[WIDTH-1]);
                            rsp_valid_reg <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_sum   = sum_reg;
    assign bus.rsp_cout  = cout_reg;
    assign bus.rsp_ovf   = ovf_reg;

endmodule
